// File: rtl/fp_move_pkg.sv
// Shared types, constants and helpers for the pipelined FP/INT move unit.
package fp_move_pkg;

  typedef enum logic [2:0] {
    OpFmvWX  = 3'd0,
    OpFmvXW  = 3'd1,
    OpFsgnj  = 3'd2,
    OpFsgnjn = 3'd3,
    OpFsgnjx = 3'd4,
    OpFclass = 3'd5,
    OpRsvd6  = 3'd6,
    OpRsvd7  = 3'd7
  } fmv_op_e;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;

  localparam int unsigned ClsNegInf  = 0;
  localparam int unsigned ClsNegNorm = 1;
  localparam int unsigned ClsNegSub  = 2;
  localparam int unsigned ClsNegZero = 3;
  localparam int unsigned ClsPosZero = 4;
  localparam int unsigned ClsPosSub  = 5;
  localparam int unsigned ClsPosNorm = 6;
  localparam int unsigned ClsPosInf  = 7;
  localparam int unsigned ClsSnan    = 8;
  localparam int unsigned ClsQnan    = 9;

  function automatic logic [63:0] nan_box(input logic [31:0] v);
    return {32'hFFFF_FFFF, v};
  endfunction

  // With boxing enabled an operand whose upper half is not all ones reads as canonical NaN.
  function automatic logic [31:0] unbox_s(input logic [63:0] v, input logic boxed);
    if (boxed && (v[63:32] != 32'hFFFF_FFFF)) return CANON_NAN_S;
    return v[31:0];
  endfunction

endpackage

// File: rtl/fp_move_core.sv
// Combinational decode and compute for FMV, FSGNJ* and FCLASS single-precision ops.
module fp_move_core import fp_move_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned FLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] int_rs1,
  input  logic [FLEN-1:0] fp_rs1,
  input  logic [FLEN-1:0] fp_rs2,
  output logic [FLEN-1:0] fp_res,
  output logic [XLEN-1:0] int_res,
  output logic            to_fp,
  output logic            illegal
);

  localparam logic Boxed = (FLEN == 64);

  fmv_op_e     op_e;
  logic [31:0] a;
  logic [31:0] b;
  logic [9:0]  cls;
  logic        sign;

  assign op_e = fmv_op_e'(op);
  assign a    = unbox_s(64'(fp_rs1), Boxed);
  assign b    = unbox_s(64'(fp_rs2), Boxed);

  always_comb begin
    cls = '0;
    if (a[30:23] == 8'hFF) begin
      if (a[22:0] == '0) begin
        if (a[31]) cls[ClsNegInf] = 1'b1;
        else       cls[ClsPosInf] = 1'b1;
      end else if (a[22]) begin
        cls[ClsQnan] = 1'b1;
      end else begin
        cls[ClsSnan] = 1'b1;
      end
    end else if (a[30:23] == 8'h00) begin
      if (a[22:0] == '0) begin
        if (a[31]) cls[ClsNegZero] = 1'b1;
        else       cls[ClsPosZero] = 1'b1;
      end else begin
        if (a[31]) cls[ClsNegSub] = 1'b1;
        else       cls[ClsPosSub] = 1'b1;
      end
    end else begin
      if (a[31]) cls[ClsNegNorm] = 1'b1;
      else       cls[ClsPosNorm] = 1'b1;
    end
  end

  always_comb begin
    fp_res  = '0;
    int_res = '0;
    to_fp   = 1'b0;
    illegal = 1'b0;
    sign    = 1'b0;
    case (op_e)
      OpFmvWX: begin
        fp_res = FLEN'(nan_box(int_rs1[31:0]));
        to_fp  = 1'b1;
      end
      // Raw low bits, deliberately bypassing the unboxing check.
      OpFmvXW: int_res = XLEN'($signed(fp_rs1[31:0]));
      OpFsgnj, OpFsgnjn, OpFsgnjx: begin
        if (op_e == OpFsgnj)       sign = b[31];
        else if (op_e == OpFsgnjn) sign = ~b[31];
        else                       sign = a[31] ^ b[31];
        fp_res = FLEN'(nan_box({sign, a[30:0]}));
        to_fp  = 1'b1;
      end
      OpFclass: int_res = XLEN'(cls);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fp_move_pipe.sv
// Elastic fixed-latency pipeline around fp_move_core with tag pass-through and flush.
module fp_move_pipe import fp_move_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  int_rs1,
  input  logic [FLEN-1:0]  fp_rs1,
  input  logic [FLEN-1:0]  fp_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_to_fp,
  output logic [TAG_W-1:0] out_tag,
  output logic [FLEN-1:0]  fp_rd,
  output logic [XLEN-1:0]  int_rd,
  output logic             out_illegal
);

  typedef struct packed {
    logic             to_fp;
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic [FLEN-1:0]  fp;
    logic [XLEN-1:0]  ir;
  } stage_t;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] move;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  stage_t            stage_q [STAGES];
  stage_t            src     [STAGES];

  logic [FLEN-1:0] core_fp;
  logic [XLEN-1:0] core_int;
  logic            core_to_fp;
  logic            core_illegal;

  fp_move_core #(
    .XLEN (XLEN),
    .FLEN (FLEN)
  ) u_core (
    .op      (in_op),
    .int_rs1 (int_rs1),
    .fp_rs1  (fp_rs1),
    .fp_rs2  (fp_rs2),
    .fp_res  (core_fp),
    .int_res (core_int),
    .to_fp   (core_to_fp),
    .illegal (core_illegal)
  );

  // A stage may move on when everything downstream of it has (or is opening) a free slot.
  always_comb begin
    logic m;
    m = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      move[k] = m;
      load[k] = !valid_q[k] || m;
      m       = !valid_q[k] || m;
    end
  end

  always_comb begin
    src_valid[0] = in_valid;
    src[0]       = '{to_fp: core_to_fp, illegal: core_illegal, tag: in_tag,
                     fp: core_fp, ir: core_int};
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src[k]       = stage_q[k-1];
    end
  end

  assign in_ready = load[0] && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (load[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) stage_q[k] <= src[k];
        end
      end
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_to_fp   = stage_q[STAGES-1].to_fp;
  assign out_illegal = stage_q[STAGES-1].illegal;
  assign out_tag     = stage_q[STAGES-1].tag;
  assign fp_rd       = stage_q[STAGES-1].fp;
  assign int_rd      = stage_q[STAGES-1].ir;

endmodule
